// File: rtl/sel_skid_stage.sv
// sel_skid_stage: two-entry skid buffer carrying an operand bus and a mux
// select to a downstream DATA_W-to-1 mux. Both handshake sides are fully
// registered: in_ready and out_valid come straight from flops, so there is
// no combinational path from out_ready to in_ready or from inputs to outputs.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  upstream handshake
//   in_data, in_sel    operand bits (bit k -> mux input k) and select
//   flush              synchronous discard of every held beat
//   out_valid/out_ready downstream handshake
//   out_data, out_sel  registered operand bits and select from main entry
//   stall_cnt          saturating back-pressure counter (only when the
//                      SKID_STALL_CNT_EN macro is defined)
//
// Optional feature macro: SKID_STALL_CNT_EN
module sel_skid_stage #(
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned DATA_W = 8   // must equal 2**SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_sel
`ifdef SKID_STALL_CNT_EN
    ,
    output logic [7:0]        stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [SEL_W-1:0]  main_sel_q,  main_sel_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0]  skid_sel_q,  skid_sel_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;

    // Datapath load strobes produced by the next-state logic.
    logic ld_main_in;
    logic ld_main_skid;
    logic ld_skid_in;

    logic accept;
    logic consume;

    assign accept  = in_valid  && in_ready_q;
    assign consume = out_valid_q && out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and load selection; flush overrides every handshake.
    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_in   = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        ld_main_in = 1'b1;
                        state_d    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        ld_main_in = 1'b1;
                    end else if (accept) begin
                        ld_skid_in = 1'b1;
                        state_d    = ST_FULL;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain side moves.
                    if (consume) begin
                        ld_main_skid = 1'b1;
                        state_d      = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Output/datapath next values; main holds its value when not loaded so
    // outputs keep the last beat while idle.
    always_comb begin
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
        if (ld_main_in) begin
            main_data_d = in_data;
            main_sel_d  = in_sel;
        end else if (ld_main_skid) begin
            main_data_d = skid_data_q;
            main_sel_d  = skid_sel_q;
        end
        if (ld_skid_in) begin
            skid_data_d = in_data;
            skid_sel_d  = in_sel;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;

`ifdef SKID_STALL_CNT_EN
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(255);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counts cycles where a valid beat is back-pressured; saturates.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sel_skid_stage.sv
// Directed testbench for sel_skid_stage: a vector table covering the
// handshake state machine plus hand-written streaming, async-reset and
// (optionally) stall-counter sequences.
module tb_sel_skid_stage;

    localparam int unsigned SEL_W  = 3;
    localparam int unsigned DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]  in_sel;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [SEL_W-1:0]  out_sel;
`ifdef SKID_STALL_CNT_EN
    logic [7:0]        stall_cnt;
`endif

    sel_skid_stage #(.SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
`ifdef SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic [2:0] s;
        logic       ordy;
        logic       fl;
        logic       ov;
        logic       ir;
        logic [7:0] od;
        logic [2:0] os;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_err;

    function automatic vec_t mk(logic iv, logic [7:0] d, logic [2:0] s,
                                logic ordy, logic fl, logic ov, logic ir,
                                logic [7:0] od, logic [2:0] os);
        vec_t v;
        v.iv = iv; v.d = d; v.s = s; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.ir = ir; v.od = od; v.os = os;
        return v;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic [2:0] s,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_sel    = s;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic ov, input logic ir,
                              input logic [7:0] od, input logic [2:0] os);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        check({tag, ".out_data"},  32'(out_data),  32'(od));
        check({tag, ".out_sel"},   32'(out_sel),   32'(os));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        // Table: inputs applied for one edge, expected post-edge outputs.
        vecs.push_back(mk(1, 8'hA5, 3'd5, 1, 0,  1, 1, 8'hA5, 3'd5)); // EMPTY accept
        vecs.push_back(mk(0, 8'h00, 3'd0, 1, 0,  0, 1, 8'hA5, 3'd5)); // drain, hold last
        vecs.push_back(mk(1, 8'h11, 3'd1, 0, 0,  1, 1, 8'h11, 3'd1));
        vecs.push_back(mk(1, 8'h22, 3'd2, 0, 0,  1, 0, 8'h11, 3'd1)); // FULL
        vecs.push_back(mk(1, 8'h44, 3'd4, 0, 0,  1, 0, 8'h11, 3'd1)); // refused, stable
        vecs.push_back(mk(0, 8'h00, 3'd0, 1, 0,  1, 1, 8'h22, 3'd2)); // skid -> main
        vecs.push_back(mk(0, 8'h00, 3'd0, 1, 0,  0, 1, 8'h22, 3'd2));
        vecs.push_back(mk(1, 8'h55, 3'd7, 0, 0,  1, 1, 8'h55, 3'd7));
        vecs.push_back(mk(1, 8'h66, 3'd6, 0, 0,  1, 0, 8'h55, 3'd7)); // FULL
        vecs.push_back(mk(1, 8'h33, 3'd3, 0, 1,  0, 1, 8'h55, 3'd7)); // flush in FULL
        vecs.push_back(mk(0, 8'h00, 3'd0, 1, 0,  0, 1, 8'h55, 3'd7)); // 33 never shows
        vecs.push_back(mk(1, 8'h77, 3'd0, 1, 0,  1, 1, 8'h77, 3'd0));
        vecs.push_back(mk(1, 8'h88, 3'd1, 1, 0,  1, 1, 8'h88, 3'd1)); // accept+consume
        vecs.push_back(mk(1, 8'h99, 3'd2, 0, 0,  1, 0, 8'h88, 3'd1)); // ONE -> FULL
        vecs.push_back(mk(0, 8'h00, 3'd0, 1, 0,  1, 1, 8'h99, 3'd2));
        vecs.push_back(mk(0, 8'h00, 3'd0, 1, 0,  0, 1, 8'h99, 3'd2));
        vecs.push_back(mk(1, 8'h12, 3'd3, 0, 0,  1, 1, 8'h12, 3'd3));
        vecs.push_back(mk(1, 8'h34, 3'd4, 1, 1,  0, 1, 8'h12, 3'd3)); // flush in ONE

        // Reset state while rst_n is low.
        #1;
        check_outs("reset", 1'b0, 1'b0, 8'h00, 3'd0);
`ifdef SKID_STALL_CNT_EN
        check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        #11 rst_n = 1'b1;   // released between edges
        tick();
        check_outs("post_reset", 1'b0, 1'b1, 8'h00, 3'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].s, vecs[i].ordy, vecs[i].fl);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].ov, vecs[i].ir, vecs[i].od, vecs[i].os);
        end

        // Back-to-back stream, no bubbles.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 3'(i % 8), 1'b1, 1'b0);
            tick();
            check_outs($sformatf("stream%0d", i), 1'b1, 1'b1, 8'(i), 3'(i % 8));
        end
        drive(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        tick();
        check_outs("stream_end", 1'b0, 1'b1, 8'd15, 3'd7);

        // Fill to FULL, then asynchronous reset mid-cycle.
        drive(1'b1, 8'hC1, 3'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'hC2, 3'd2, 1'b0, 1'b0);
        tick();
        check_outs("pre_async", 1'b1, 1'b0, 8'hC1, 3'd1);
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 8'h00, 3'd0);
        #3 rst_n = 1'b1;
        tick();
        check_outs("async_rel", 1'b0, 1'b1, 8'h00, 3'd0);
        drive(1'b1, 8'h5A, 3'd3, 1'b1, 1'b0);
        tick();
        check_outs("after_rst_beat", 1'b1, 1'b1, 8'h5A, 3'd3);
        drive(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        tick();
        check_outs("after_rst_drain", 1'b0, 1'b1, 8'h5A, 3'd3);

`ifdef SKID_STALL_CNT_EN
        // Saturating stall counter, cleared by flush.
        drive(1'b1, 8'hE7, 3'd6, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        check("stall_cnt.first", 32'(stall_cnt), 32'd1);
        for (int i = 0; i < 300; i++) tick();
        check("stall_cnt.sat", 32'(stall_cnt), 32'd255);
        check("stall_cnt.hold_data", 32'(out_data), 32'hE7);
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        tick();
        check("stall_cnt.flush", 32'(stall_cnt), 32'd0);
        check("stall_cnt.flush_ov", 32'(out_valid), 32'd0);
        drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
